// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and the parity helper used by RX and TX.
// Parity helper takes a 9-bit zero-padded word so any 5..9 bit frame fits.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit for a zero-padded data word.
    function automatic logic uart_parity(
        input logic [MAX_DATA_BITS-1:0] data,
        input parity_e                  mode
    );
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_os_fifo.sv
// uart_rx_os_fifo: small synchronous FIFO with a ready/valid read side.
// Writes are dropped when full; rdata shows the head entry while valid.
module uart_rx_os_fifo #(
    parameter int data_size   = 8,
    parameter int buffer_size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [data_size-1:0] wdata,
    input  logic                 pop,
    output logic [data_size-1:0] rdata,
    output logic                 rvalid,
    output logic                 full
);

    localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(buffer_size - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(buffer_size);

    logic [data_size-1:0] mem [buffer_size];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 wr_en;
    logic                 rd_en;

    assign full   = (count == CNT_FULL);
    assign rvalid = (count != '0);
    assign rdata  = mem[rd_ptr];
    assign wr_en  = push && !full;
    assign rd_en  = pop && rvalid;

    // Storage, pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < buffer_size; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with parity/stop checking,
// a receive FIFO and occupancy-driven cts_n back-pressure.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_EVEN,
    parameter int      STOP_BITS  = 2,
    parameter int      OVERSAMPLE = 16,
    parameter int      DIV_W      = 16,
    parameter int      FIFO_DEPTH = 8,
    parameter int      CTS_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic                 cts_n,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int OCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] BIT_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    logic                     rx_m;
    logic                     rx_s;
    logic [DIV_W-1:0]         div_cnt;
    logic                     tick;
    logic                     half_pt;
    logic                     bit_pt;
    rx_state_e                state;
    rx_state_e                state_nx;
    logic [OSW-1:0]           os_cnt;
    logic [BCW-1:0]           bit_cnt;
    logic [DATA_BITS-1:0]     shreg;
    logic [MAX_DATA_BITS-1:0] par_in;
    logic                     par_exp;
    logic                     par_bad;
    logic                     stop_bad;
    logic                     commit;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic [OCW-1:0]           occ;

    assign tick    = (state != IDLE) && (div_cnt == baud_div);
    assign half_pt = tick && (os_cnt == HALF_LAST);
    assign bit_pt  = tick && (os_cnt == BIT_LAST);
    assign pop     = rvalid && rready;

    // Zero-pad the received word for the shared parity helper.
    always_comb begin
        par_in                 = '0;
        par_in[DATA_BITS-1:0]  = shreg;
        par_exp                = uart_parity(par_in, PARITY);
    end

    // Two-flop synchroniser for the asynchronous rx pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Oversample tick divider, held in reset while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; disabling the receiver aborts any frame.
    always_comb begin
        state_nx = state;
        if (!rx_en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) state_nx = START;
                end
                START: begin
                    if (half_pt) state_nx = rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_pt && bit_cnt == DATA_LAST) begin
                        state_nx = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end
                end
                uart_pkg::PARITY: begin
                    if (bit_pt) state_nx = STOP;
                end
                STOP: begin
                    if (bit_pt && bit_cnt == STOP_LAST) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Bit timing, data shift and error capture for the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            commit   <= 1'b0;
        end else begin
            commit <= rx_en && state == STOP && bit_pt && bit_cnt == STOP_LAST;
            case (state)
                START: begin
                    bit_cnt  <= '0;
                    par_bad  <= 1'b0;
                    stop_bad <= 1'b0;
                    if (tick) os_cnt <= half_pt ? '0 : os_cnt + 1'b1;
                end
                DATA: begin
                    if (tick) os_cnt <= bit_pt ? '0 : os_cnt + 1'b1;
                    if (bit_pt) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) os_cnt <= bit_pt ? '0 : os_cnt + 1'b1;
                    if (bit_pt) par_bad <= (rx_s != par_exp);
                end
                STOP: begin
                    if (tick) os_cnt <= bit_pt ? '0 : os_cnt + 1'b1;
                    if (bit_pt) begin
                        stop_bad <= stop_bad | ~rx_s;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    os_cnt <= '0;
                end
            endcase
        end
    end

    // Commit outcome: first matching error wins, otherwise push.
    always_comb begin
        parity_err  = commit && par_bad;
        frame_err   = commit && !par_bad && stop_bad;
        overrun_err = commit && !par_bad && !stop_bad && full;
        push        = commit && !par_bad && !stop_bad && !full;
    end

    // Occupancy tracking and registered back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= '0;
            cts_n <= 1'b1;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            cts_n <= !rx_en || ((FIFO_DEPTH - int'(occ)) <= CTS_MARGIN);
        end
    end

    uart_rx_os_fifo #(
        .data_size   (DATA_BITS),
        .buffer_size (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wdata  (shreg),
        .pop    (pop),
        .rdata  (rdata),
        .rvalid (rvalid),
        .full   (full)
    );

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed + random frames against a queue-based model
// of the receiver's word stream and error outcomes.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int DB      = 8;
    localparam int DEPTH   = 8;
    localparam int BIT_CLK = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   baud_div;
    logic          rx_en;
    logic          rx;
    logic          rready;
    logic          cts_n;
    logic [DB-1:0] rdata;
    logic          rvalid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;

    uart_rx_os dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div    (baud_div),
        .rx_en       (rx_en),
        .rx          (rx),
        .cts_n       (cts_n),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rready      (rready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovr = 0;
    int n_multi = 0;
    int n_vcyc = 0;
    logic [DB-1:0] got[$];

    logic [DB-1:0] mq[$];
    int rd_idx = 0;
    int e_par = 0;
    int e_frm = 0;
    int e_ovr = 0;

    // Observe the read port and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rvalid && rready) got.push_back(rdata);
            if (rvalid) n_vcyc++;
            if (parity_err) n_par++;
            if (frame_err) n_frm++;
            if (overrun_err) n_ovr++;
            if (int'(parity_err) + int'(frame_err) + int'(overrun_err) > 1)
                n_multi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    // Serialise one frame (even parity, 2 stops) and update the model.
    task automatic send_frame(input logic [DB-1:0] d, input bit bad_par,
                              input bit bad_stop);
        logic pbit;
        pbit = (($countones(d) % 2) == 1) ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(1'b1);
        drive_bit(!bad_stop);
        rx = 1'b1;
        if (bad_par) e_par++;
        else if (bad_stop) e_frm++;
        else if (mq.size() == DEPTH) e_ovr++;
        else mq.push_back(d);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_drain(input string tag);
        int n;
        n = got.size() - rd_idx;
        check({tag, "_count"}, n, mq.size());
        while (n > 0 && mq.size() > 0) begin
            check({tag, "_word"}, got[rd_idx], mq[0]);
            rd_idx++;
            n--;
            void'(mq.pop_front());
        end
        mq.delete();
        rd_idx = got.size();
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_par"}, n_par, e_par);
        check({tag, "_frm"}, n_frm, e_frm);
        check({tag, "_ovr"}, n_ovr, e_ovr);
    endtask

    initial begin
        logic [DB-1:0] d;
        int v0;

        rst_n    = 1'b0;
        rx_en    = 1'b0;
        rx       = 1'b1;
        rready   = 1'b0;
        baud_div = 16'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cts_n", cts_n, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_errs", {parity_err, frame_err, overrun_err}, 0);

        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_cts_n", cts_n, 0);

        // Good frame, consumer always ready.
        rready = 1'b1;
        v0 = n_vcyc;
        send_frame(8'hA5, 1'b0, 1'b0);
        check("t1_rvalid_cycles", n_vcyc - v0, 1);
        check_drain("t1");
        check_errs("t1");
        for (int i = 0; i < 4; i++) begin
            d = DB'($urandom);
            send_frame(d, 1'b0, 1'b0);
        end
        check_drain("t1_rand");
        check_errs("t1_rand");

        // Parity error drops the word.
        v0 = n_vcyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t2_rvalid_cycles", n_vcyc - v0, 0);
        d = DB'($urandom);
        send_frame(d, 1'b1, 1'b0);
        check_errs("t2");
        check_drain("t2");

        // Bad second stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b1);
        d = DB'($urandom);
        send_frame(d, 1'b0, 1'b0);
        check_errs("t3");
        check_drain("t3");

        // Short glitch on rx.
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_errs("t4");
        check_drain("t4");
        d = DB'($urandom);
        send_frame(d, 1'b0, 1'b0);
        check_drain("t4_after");

        // Back-pressure and overrun with the consumer stalled.
        rready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d = DB'($urandom);
            send_frame(d, 1'b0, 1'b0);
            if (i == 4) check("t5_cts_5", cts_n, 0);
            if (i == 5) check("t5_cts_6", cts_n, 1);
            if (i == 7) begin
                check("t5_rvalid_8", rvalid, 1);
                check("t5_ovr_8", n_ovr, e_ovr);
            end
        end
        check_errs("t5");
        check("t5_rvalid", rvalid, 1);
        check("t5_head", rdata, mq[0]);
        rready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_drain("t5");
        check("t5_cts_drained", cts_n, 0);

        // Disable mid-frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_en = 1'b0;
        rx    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_cts_dis", cts_n, 1);
        repeat (800) @(posedge clk);
        #1;
        check_errs("t6_dis");
        check_drain("t6_dis");
        rx_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_cts_en", cts_n, 0);
        d = DB'($urandom);
        send_frame(d, 1'b0, 1'b0);
        check_drain("t6_en");
        check_errs("t6_en");

        // Reset mid-frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("t6_rst_cts_n", cts_n, 1);
        check("t6_rst_rvalid", rvalid, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        d = DB'($urandom);
        send_frame(d, 1'b0, 1'b0);
        check_drain("t6_rst");
        check_errs("t6_rst");
        check("multi_err", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
